// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for a single register-file write port, with per-source holding
// entries, WAW age ordering and a pending-write scoreboard. Optional bypass outputs: REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              WB,
  output logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rs1_address,
  input  logic [ADDR_W-1:0] rs2_address,
  output logic              rs1_busy,
  output logic              rs2_busy
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic              rs1_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs2_fwd_data
`endif
);

  logic              hv0_r, hv1_r;
  logic              old0_r, old1_r;
  logic [ADDR_W-1:0] hrd0_r, hrd1_r;
  logic [DATA_W-1:0] hdata0_r, hdata1_r;
  logic              last_grant_r;

  logic              sel1_s, gnt0_s, gnt1_s;
  logic              load0_s, load1_s;
  logic [ADDR_W-1:0] rd_s;
  logic [DATA_W-1:0] wdata_s;

  // Arbitration: age decides same-rd conflicts, otherwise fixed or round-robin priority.
  always_comb begin
    sel1_s = 1'b0;
    if (hv0_r && hv1_r) begin
      if (hrd0_r == hrd1_r) begin
        sel1_s = old1_r;
      end else if (FIXED_PRIO != 0) begin
        sel1_s = 1'b0;
      end else begin
        sel1_s = ~last_grant_r;
      end
    end else begin
      sel1_s = hv1_r & ~hv0_r;
    end
  end

  assign gnt0_s     = hv0_r & ~sel1_s;
  assign gnt1_s     = hv1_r & sel1_s;
  assign req0_ready = ~hv0_r | gnt0_s;
  assign req1_ready = ~hv1_r | gnt1_s;
  // Writes to x0 are acknowledged but never occupy a holding entry.
  assign load0_s    = req0_valid & req0_ready & (req0_rd != '0);
  assign load1_s    = req1_valid & req1_ready & (req1_rd != '0);

  // Write-port mux from the granted entry, zero when idle.
  always_comb begin
    rd_s    = '0;
    wdata_s = '0;
    if (gnt1_s) begin
      rd_s    = hrd1_r;
      wdata_s = hdata1_r;
    end else if (gnt0_s) begin
      rd_s    = hrd0_r;
      wdata_s = hdata0_r;
    end else begin
      rd_s    = '0;
      wdata_s = '0;
    end
  end

  assign WB         = hv0_r | hv1_r;
  assign rd_address = rd_s;
  assign write_data = wdata_s;
  assign rs1_busy   = (rs1_address != '0) &
                      ((hv0_r & (hrd0_r == rs1_address)) | (hv1_r & (hrd1_r == rs1_address)));
  assign rs2_busy   = (rs2_address != '0) &
                      ((hv0_r & (hrd0_r == rs2_address)) | (hv1_r & (hrd1_r == rs2_address)));

  // Source 0 holding entry; a surviving entry becomes old when the other source loads its rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv0_r    <= 1'b0;
      old0_r   <= 1'b0;
      hrd0_r   <= '0;
      hdata0_r <= '0;
    end else if (load0_s) begin
      hv0_r    <= 1'b1;
      old0_r   <= 1'b0;
      hrd0_r   <= req0_rd;
      hdata0_r <= req0_data;
    end else if (gnt0_s) begin
      hv0_r    <= 1'b0;
      old0_r   <= 1'b0;
    end else if (hv0_r && load1_s && (req1_rd == hrd0_r)) begin
      old0_r   <= 1'b1;
    end
  end

  // Source 1 holding entry, mirror of source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv1_r    <= 1'b0;
      old1_r   <= 1'b0;
      hrd1_r   <= '0;
      hdata1_r <= '0;
    end else if (load1_s) begin
      hv1_r    <= 1'b1;
      old1_r   <= 1'b0;
      hrd1_r   <= req1_rd;
      hdata1_r <= req1_data;
    end else if (gnt1_s) begin
      hv1_r    <= 1'b0;
      old1_r   <= 1'b0;
    end else if (hv1_r && load0_s && (req0_rd == hrd1_r)) begin
      old1_r   <= 1'b1;
    end
  end

  // Round-robin memory: remembers the winner of the last two-way contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (hv0_r && hv1_r) begin
      last_grant_r <= sel1_s;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Bypass of the value being written this cycle.
  always_comb begin
    rs1_fwd_valid = WB & (rd_s == rs1_address) & (rs1_address != '0);
    rs2_fwd_valid = WB & (rd_s == rs2_address) & (rs2_address != '0);
    if (rs1_fwd_valid) begin
      rs1_fwd_data = wdata_s;
    end else begin
      rs1_fwd_data = '0;
    end
    if (rs2_fwd_valid) begin
      rs2_fwd_data = wdata_s;
    end else begin
      rs2_fwd_data = '0;
    end
  end
`endif

endmodule
